junction_phase_scheduler: RTL and testbench



---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/phase_timer.sv | 31 +++
 rtl/junction_phase_scheduler.sv | 153 +++++++++++++++
 tb/tb_junction_phase_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the junction phase scheduler: light codes, phase
// codes and the decode from a phase to the lamp outputs it drives.
package traffic_pkg;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } light_e;

   typedef enum logic [2:0] {
      S_HG  = 3'd0,
      S_HY  = 3'd1,
      S_AR1 = 3'd2,
      S_CG  = 3'd3,
      S_CY  = 3'd4,
      S_AR2 = 3'd5,
      S_PW  = 3'd6
   } phase_e;

   typedef struct packed {
      light_e hwy;
      light_e cntry;
      logic   walk;
   } lights_t;

   // Lamp pattern for each phase; anything unexpected shows all-red.
   function automatic lights_t decode_lights(input phase_e st);
      lights_t l;
      l.hwy   = RED;
      l.cntry = RED;
      l.walk  = 1'b0;
      case (st)
         S_HG:    l.hwy   = GREEN;
         S_HY:    l.hwy   = YELLOW;
         S_CG:    l.cntry = GREEN;
         S_CY:    l.cntry = YELLOW;
         S_PW:    l.walk  = 1'b1;
         default: l.walk  = 1'b0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter that saturates at zero; done flags the last cycle
// of the interval that was loaded.
module phase_timer #(
   parameter int TW      = 8,
   parameter int RST_VAL = 0
) (
   input  logic          clock,
   input  logic          clear,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          done
);

   logic [TW-1:0] r_count;

   // Reload on phase entry, otherwise count down and hold at zero.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_count <= TW'(RST_VAL);
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - TW'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign done = (r_count == '0);

endmodule

// File: rtl/junction_phase_scheduler.sv
// Two-road junction light sequencer with pedestrian walk insertion.
// Highway keeps right-of-way; country road and pedestrian requests are
// latched into pending flags and served after yellow + all-red clearance.
// Optional build macro EMERGENCY_PREEMPT_EN adds the emg input that
// forces the highway back to green.
module junction_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int TW              = 8,
   parameter int MIN_HWY_GREEN   = 20,
   parameter int MAX_CNTRY_GREEN = 15,
   parameter int YELLOW_T        = 3,
   parameter int ALL_RED_T       = 2,
   parameter int WALK_T          = 10
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       x,
   input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
   input  logic       emg,
`endif
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   localparam int LIMIT = 1 << TW;

   if (MIN_HWY_GREEN < 1 || MIN_HWY_GREEN >= LIMIT ||
       MAX_CNTRY_GREEN < 1 || MAX_CNTRY_GREEN >= LIMIT ||
       YELLOW_T < 1 || YELLOW_T >= LIMIT ||
       ALL_RED_T < 1 || ALL_RED_T >= LIMIT ||
       WALK_T < 1 || WALK_T >= LIMIT) begin : g_bad_duration
      $error("junction_phase_scheduler: every duration must be in [1, 2^TW)");
   end

   phase_e        r_state;
   phase_e        w_next;
   logic          r_cnt_pend;
   logic          r_ped_pend;
   logic          r_ped_ack;
   logic          w_done;
   logic          w_enter;
   logic          w_emg;
   logic [TW-1:0] w_load_val;
   lights_t       w_lights;

`ifdef EMERGENCY_PREEMPT_EN
   assign w_emg = emg;
`else
   assign w_emg = 1'b0;
`endif

   // Timer reload value (duration minus one) for the phase being entered.
   function automatic logic [TW-1:0] dur_m1(input phase_e s);
      case (s)
         S_HG:         return TW'(MIN_HWY_GREEN - 1);
         S_HY, S_CY:   return TW'(YELLOW_T - 1);
         S_AR1, S_AR2: return TW'(ALL_RED_T - 1);
         S_CG:         return TW'(MAX_CNTRY_GREEN - 1);
         S_PW:         return TW'(WALK_T - 1);
         default:      return TW'(MIN_HWY_GREEN - 1);
      endcase
   endfunction

   phase_timer #(
      .TW      (TW),
      .RST_VAL (MIN_HWY_GREEN - 1)
   ) u_timer (
      .clock    (clock),
      .clear    (clear),
      .load     (w_enter),
      .load_val (w_load_val),
      .done     (w_done)
   );

   // Next-phase selection; pedestrian is served ahead of the country road.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_HG: begin
            if (w_done && (r_cnt_pend || r_ped_pend) && !w_emg) w_next = S_HY;
            else w_next = S_HG;
         end
         S_HY: begin
            if (w_done) w_next = S_AR1;
            else w_next = S_HY;
         end
         S_AR1: begin
            if (!w_done)        w_next = S_AR1;
            else if (w_emg)      w_next = S_HG;
            else if (r_ped_pend) w_next = S_PW;
            else if (r_cnt_pend) w_next = S_CG;
            else                 w_next = S_HG;
         end
         S_CG: begin
            if (w_emg || !x || w_done) w_next = S_CY;
            else w_next = S_CG;
         end
         S_CY: begin
            if (w_done) w_next = S_AR2;
            else w_next = S_CY;
         end
         S_AR2: begin
            if (!w_done)        w_next = S_AR2;
            else if (w_emg)      w_next = S_HG;
            else if (r_ped_pend) w_next = S_PW;
            else                 w_next = S_HG;
         end
         S_PW: begin
            if (!w_done)        w_next = S_PW;
            else if (w_emg)      w_next = S_HG;
            else if (r_cnt_pend) w_next = S_CG;
            else                 w_next = S_HG;
         end
         default: w_next = S_HG;
      endcase
   end

   assign w_enter    = (w_next != r_state);
   assign w_load_val = dur_m1(w_next);

   // Phase register, pending-request flags and the one-cycle acknowledge.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state    <= S_HG;
         r_cnt_pend <= 1'b0;
         r_ped_pend <= 1'b0;
         r_ped_ack  <= 1'b0;
      end else begin
         r_state <= w_next;
         // A request on the same edge the flag is consumed is dropped.
         if (w_enter && (w_next == S_CG))   r_cnt_pend <= 1'b0;
         else if (x && (r_state != S_CG))   r_cnt_pend <= 1'b1;
         else                               r_cnt_pend <= r_cnt_pend;
         if (w_enter && (w_next == S_PW))   r_ped_pend <= 1'b0;
         else if (ped_req && (r_state != S_PW)) r_ped_pend <= 1'b1;
         else                               r_ped_pend <= r_ped_pend;
         r_ped_ack <= w_enter && (w_next == S_PW);
      end
   end

   assign w_lights = decode_lights(r_state);
   assign hwy      = w_lights.hwy;
   assign cntry    = w_lights.cntry;
   assign walk     = w_lights.walk;
   assign ped_ack  = r_ped_ack;
   assign phase    = r_state;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Self-checking bench for junction_phase_scheduler: an elapsed-time model
// of the phase rules is compared on every cycle, and directed scenarios
// pin the model against hand-computed cycle numbers.
module tb_junction_phase_scheduler;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic       x = 1'b0;
   logic       ped_req = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
   logic       emg = 1'b0;
`endif
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   int n_checks = 0;
   int n_fail   = 0;

   // model: phase number, cycles elapsed in phase, pending requests
   int m_ph = 0;
   int m_el = 0;
   bit m_cp = 1'b0;
   bit m_pp = 1'b0;
   bit m_ack = 1'b0;
   bit model_valid = 1'b0;

   junction_phase_scheduler dut (
      .clock   (clock),
      .clear   (clear),
      .x       (x),
      .ped_req (ped_req),
`ifdef EMERGENCY_PREEMPT_EN
      .emg     (emg),
`endif
      .hwy     (hwy),
      .cntry   (cntry),
      .walk    (walk),
      .ped_ack (ped_ack),
      .phase   (phase)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dur(input int p);
      case (p)
         0: return 20;
         1: return 3;
         2: return 2;
         3: return 15;
         4: return 3;
         5: return 2;
         6: return 10;
         default: return 1;
      endcase
   endfunction

   function automatic int exp_hwy(input int p);
      return (p == 0) ? 2 : (p == 1) ? 1 : 0;
   endfunction

   function automatic int exp_cntry(input int p);
      return (p == 3) ? 2 : (p == 4) ? 1 : 0;
   endfunction

   task automatic model_step(input bit xv, input bit pv, input bit cv);
      int nxt;
      bit done;
      if (cv) begin
         m_ph = 0; m_el = 0; m_cp = 0; m_pp = 0; m_ack = 0;
      end else begin
         done = (m_el + 1 >= dur(m_ph));
         nxt  = m_ph;
         case (m_ph)
            0: if (done && (m_cp || m_pp)) nxt = 1;
            1: if (done) nxt = 2;
            2: if (done) nxt = m_pp ? 6 : (m_cp ? 3 : 0);
            3: if (!xv || done) nxt = 4;
            4: if (done) nxt = 5;
            5: if (done) nxt = m_pp ? 6 : 0;
            6: if (done) nxt = m_cp ? 3 : 0;
            default: nxt = 0;
         endcase
         if (nxt != m_ph && nxt == 3) m_cp = 0;
         else if (xv && m_ph != 3)    m_cp = 1;
         if (nxt != m_ph && nxt == 6) m_pp = 0;
         else if (pv && m_ph != 6)    m_pp = 1;
         m_ack = (nxt != m_ph && nxt == 6);
         if (nxt != m_ph) m_el = 0;
         else if (m_el < 1000) m_el++;
         m_ph = nxt;
      end
   endtask

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clock) begin
      if (model_valid) begin
         chk("model_hwy",   {6'd0, hwy},    8'(exp_hwy(m_ph)));
         chk("model_cntry", {6'd0, cntry},  8'(exp_cntry(m_ph)));
         chk("model_walk",  {7'd0, walk},   {7'd0, (m_ph == 6)});
         chk("model_ack",   {7'd0, ped_ack}, {7'd0, m_ack});
         chk("model_phase", {5'd0, phase},  8'(m_ph));
      end
   end

   task automatic step(input bit xv, input bit pv, input bit cv);
      x = xv; ped_req = pv; clear = cv;
      @(posedge clock);
      model_step(xv, pv, cv);
      @(negedge clock);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
      model_valid = 1'b1;
   endtask

   task automatic wait_phase(input string name, input int target, input bit xv, input int budget);
      int n = 0;
      while (phase != 3'(target) && n < budget) begin
         step(xv, 1'b0, 1'b0);
         n++;
      end
      chk(name, {5'd0, phase}, 8'(target));
   endtask

   task automatic run_len(input string name, input int ph, input bit xv, input int expv);
      int n = 0;
      while (phase == 3'(ph) && n < 60) begin
         step(xv, 1'b0, 1'b0);
         n++;
      end
      chk(name, 8'(n), 8'(expv));
   endtask

   initial begin
      bit xr;
      @(negedge clock);

      // reset state and idle hold
      do_reset(5);
      chk("rst_hwy", {6'd0, hwy}, 8'd2);
      chk("rst_cntry", {6'd0, cntry}, 8'd0);
      chk("rst_walk", {7'd0, walk}, 8'd0);
      chk("rst_ack", {7'd0, ped_ack}, 8'd0);
      chk("rst_phase", {5'd0, phase}, 8'd0);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0);
      chk("idle_hwy", {6'd0, hwy}, 8'd2);
      chk("idle_phase", {5'd0, phase}, 8'd0);

      // pedestrian pulse during cycle 3
      do_reset(5);
      for (int c = 1; c <= 40; c++) begin
         step(1'b0, (c == 4), 1'b0);
         if (c == 19) chk("ped_hg_end", {5'd0, phase}, 8'd0);
         if (c == 20) chk("ped_hy", {5'd0, phase}, 8'd1);
         if (c == 24) chk("ped_ar1", {5'd0, phase}, 8'd2);
         if (c == 25) begin
            chk("ped_walk_first", {7'd0, walk}, 8'd1);
            chk("ped_ack_first", {7'd0, ped_ack}, 8'd1);
            chk("ped_lights_red", {4'd0, hwy, cntry}, 8'd0);
         end
         if (c == 26) chk("ped_ack_once", {7'd0, ped_ack}, 8'd0);
         if (c == 34) chk("ped_walk_last", {7'd0, walk}, 8'd1);
         if (c == 35) chk("ped_back_hg", {5'd0, phase}, 8'd0);
      end

      // country cycle: x high during cycles 5..30
      do_reset(5);
      for (int c = 1; c <= 60; c++) begin
         step((c >= 6 && c <= 31), 1'b0, 1'b0);
         if (c == 20) chk("cty_hy", {6'd0, hwy}, 8'd1);
         if (c == 25) chk("cty_cg", {6'd0, cntry}, 8'd2);
         if (c == 31) chk("cty_cg_last", {5'd0, phase}, 8'd3);
         if (c == 32) chk("cty_cy", {6'd0, cntry}, 8'd1);
         if (c == 35) chk("cty_ar2", {5'd0, phase}, 8'd5);
         if (c == 37) chk("cty_hg", {6'd0, hwy}, 8'd2);
         if (c == 60) chk("cty_stay_hg", {5'd0, phase}, 8'd0);
      end

      // country max-green with x held high
      do_reset(3);
      wait_phase("max_reach_cg", 3, 1'b1, 100);
      run_len("max_cg_len", 3, 1'b1, 15);
      run_len("max_cy_len", 4, 1'b1, 3);
      run_len("max_ar2_len", 5, 1'b1, 2);
      run_len("max_hg_len", 0, 1'b1, 20);
      run_len("max_hy_len", 1, 1'b1, 3);

      // simultaneous x and ped_req: walk first, then country green
      do_reset(3);
      step(1'b1, 1'b1, 1'b0);
      wait_phase("sim_reach_pw", 6, 1'b1, 100);
      run_len("sim_pw_len", 6, 1'b1, 10);
      chk("sim_pw_to_cg", {5'd0, phase}, 8'd3);

      // reset mid country green with a pedestrian pending
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      chk("mid_rst_hwy", {6'd0, hwy}, 8'd2);
      chk("mid_rst_cntry", {6'd0, cntry}, 8'd0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
      chk("mid_rst_no_pend", {5'd0, phase}, 8'd0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      run_len("mid_rst_hg_len", 0, 1'b1, 19);

      // randomized traffic against the model
      do_reset(2);
      xr = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 14) == 0) xr = ~xr;
         step(xr, ($urandom_range(0, 59) == 0), ($urandom_range(0, 499) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
